// File: rtl/stack_controller.sv
// Moore control FSM for the 8-bit stack-machine datapath.
// Optional macro STACK_CTRL_JZ_POP_EN: JZ also pops the tested stack entry.
module stack_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       pcSrc,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       MtoS,
    output logic       ldA,
    output logic       ldB,
    output logic       srcA,
    output logic       srcB,
    output logic       push,
    output logic       pop,
    output logic       tos,
    output logic [1:0] ALUOp
);

    // state  | meaning
    // INIT   | post-reset idle, all strobes low
    // IF     | fetch IR <= mem[PC], PC <= PC+1
    // ID     | decode opcode
    // POP1   | pop top into A
    // POP2   | pop next into B (skipped for NOT)
    // EXEC   | ALU op, result register captures
    // WB     | push ALU result
    // MEMRD  | MDR <= mem[IR[4:0]]
    // PUSHWB | push MDR
    // POPA   | pop top into A
    // MEMWR  | mem[IR[4:0]] <= A
    // JMP    | PC <= IR[4:0]
    // JZ     | PC <= IR[4:0] if top of stack is zero
    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_IF     = 4'd1,
        S_ID     = 4'd2,
        S_POP1   = 4'd3,
        S_POP2   = 4'd4,
        S_EXEC   = 4'd5,
        S_WB     = 4'd6,
        S_MEMRD  = 4'd7,
        S_PUSHWB = 4'd8,
        S_POPA   = 4'd9,
        S_MEMWR  = 4'd10,
        S_JMP    = 4'd11,
        S_JZ     = 4'd12
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_INIT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d     = S_IF;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        pcSrc       = 1'b0;
        IorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        IRWrite     = 1'b0;
        MtoS        = 1'b0;
        ldA         = 1'b0;
        ldB         = 1'b0;
        srcA        = 1'b0;
        srcB        = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        tos         = 1'b0;
        ALUOp       = 2'b00;
        case (state_q)
            S_INIT: state_d = S_IF;
            S_IF: begin
                memRead = 1'b1;
                IRWrite = 1'b1;
                srcA    = 1'b1;
                srcB    = 1'b1;
                pcWrite = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                if (!opcode[2]) state_d = S_POP1;
                else begin
                    case (opcode[1:0])
                        2'b00:   state_d = S_MEMRD;
                        2'b01:   state_d = S_POPA;
                        2'b10:   state_d = S_JMP;
                        default: state_d = S_JZ;
                    endcase
                end
            end
            S_POP1: begin
                tos     = 1'b1;
                pop     = 1'b1;
                ldA     = 1'b1;
                state_d = (opcode == 3'b011) ? S_EXEC : S_POP2;
            end
            S_POP2: begin
                tos     = 1'b1;
                pop     = 1'b1;
                ldB     = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                ALUOp   = opcode[1:0];
                state_d = S_WB;
            end
            S_WB: push = 1'b1;
            S_MEMRD: begin
                IorD    = 1'b1;
                memRead = 1'b1;
                state_d = S_PUSHWB;
            end
            S_PUSHWB: begin
                push = 1'b1;
                MtoS = 1'b1;
            end
            S_POPA: begin
                tos     = 1'b1;
                pop     = 1'b1;
                ldA     = 1'b1;
                state_d = S_MEMWR;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                memWrite = 1'b1;
            end
            S_JMP: begin
                pcWrite = 1'b1;
                pcSrc   = 1'b1;
            end
            S_JZ: begin
                tos         = 1'b1;
                pcWriteCond = 1'b1;
                pcSrc       = 1'b1;
`ifdef STACK_CTRL_JZ_POP_EN
                pop         = 1'b1;
`else
                pop         = 1'b0;
`endif
            end
            default: state_d = S_IF;
        endcase
    end

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller: per-cycle strobe traces per opcode plus async reset.
module tb_stack_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic       pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS;
    logic       ldA, ldB, srcA, srcB, push, pop, tos;
    logic [1:0] ALUOp;

    int n_checks = 0;
    int n_errors = 0;

    stack_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc), .IorD(IorD),
        .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite), .MtoS(MtoS),
        .ldA(ldA), .ldB(ldB), .srcA(srcA), .srcB(srcB),
        .push(push), .pop(pop), .tos(tos), .ALUOp(ALUOp)
    );

    always #5 clk = ~clk;

    logic [16:0] outs;
    assign outs = {pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS,
                   ldA, ldB, srcA, srcB, push, pop, tos, ALUOp};

    localparam logic [16:0] B_PCW   = 17'd1 << 16;
    localparam logic [16:0] B_PCWC  = 17'd1 << 15;
    localparam logic [16:0] B_PCSRC = 17'd1 << 14;
    localparam logic [16:0] B_IORD  = 17'd1 << 13;
    localparam logic [16:0] B_MRD   = 17'd1 << 12;
    localparam logic [16:0] B_MWR   = 17'd1 << 11;
    localparam logic [16:0] B_IRW   = 17'd1 << 10;
    localparam logic [16:0] B_MTOS  = 17'd1 << 9;
    localparam logic [16:0] B_LDA   = 17'd1 << 8;
    localparam logic [16:0] B_LDB   = 17'd1 << 7;
    localparam logic [16:0] B_SRCA  = 17'd1 << 6;
    localparam logic [16:0] B_SRCB  = 17'd1 << 5;
    localparam logic [16:0] B_PUSH  = 17'd1 << 4;
    localparam logic [16:0] B_POP   = 17'd1 << 3;
    localparam logic [16:0] B_TOS   = 17'd1 << 2;

    localparam logic [16:0] E_ZERO   = 17'd0;
    localparam logic [16:0] E_IF     = B_PCW | B_MRD | B_IRW | B_SRCA | B_SRCB;
    localparam logic [16:0] E_POP1   = B_TOS | B_POP | B_LDA;
    localparam logic [16:0] E_POP2   = B_TOS | B_POP | B_LDB;
    localparam logic [16:0] E_EXADD  = 17'd0;
    localparam logic [16:0] E_EXSUB  = 17'd1;
    localparam logic [16:0] E_EXAND  = 17'd2;
    localparam logic [16:0] E_EXNOT  = 17'd3;
    localparam logic [16:0] E_WB     = B_PUSH;
    localparam logic [16:0] E_MEMRD  = B_IORD | B_MRD;
    localparam logic [16:0] E_PUSHWB = B_PUSH | B_MTOS;
    localparam logic [16:0] E_MEMWR  = B_IORD | B_MWR;
    localparam logic [16:0] E_JMP    = B_PCW | B_PCSRC;
`ifdef STACK_CTRL_JZ_POP_EN
    localparam logic [16:0] E_JZ     = B_PCWC | B_PCSRC | B_TOS | B_POP;
`else
    localparam logic [16:0] E_JZ     = B_PCWC | B_PCSRC | B_TOS;
`endif

    logic [16:0] trace [8];

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // Starts in an IF cycle (at negedge); returns at the negedge of the next IF cycle.
    task automatic run_instr(input string name, input logic [2:0] op, input int len);
        opcode = op;
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s_c%0d", name, i + 1), outs, trace[i]);
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", outs, E_ZERO);
        end
        rst = 1'b1;
        #1 check("init_after_release", outs, E_ZERO);
        @(negedge clk);

        trace = '{E_IF, E_ZERO, E_POP1, E_POP2, E_EXADD, E_WB, E_ZERO, E_ZERO};
        run_instr("add", 3'b000, 6);
        trace = '{E_IF, E_ZERO, E_POP1, E_POP2, E_EXSUB, E_WB, E_ZERO, E_ZERO};
        run_instr("sub", 3'b001, 6);
        trace = '{E_IF, E_ZERO, E_POP1, E_POP2, E_EXAND, E_WB, E_ZERO, E_ZERO};
        run_instr("and", 3'b010, 6);
        trace = '{E_IF, E_ZERO, E_POP1, E_EXNOT, E_WB, E_ZERO, E_ZERO, E_ZERO};
        run_instr("not", 3'b011, 5);
        trace = '{E_IF, E_ZERO, E_MEMRD, E_PUSHWB, E_ZERO, E_ZERO, E_ZERO, E_ZERO};
        run_instr("push", 3'b100, 4);
        trace = '{E_IF, E_ZERO, E_POP1, E_MEMWR, E_ZERO, E_ZERO, E_ZERO, E_ZERO};
        run_instr("pop", 3'b101, 4);
        trace = '{E_IF, E_ZERO, E_JMP, E_ZERO, E_ZERO, E_ZERO, E_ZERO, E_ZERO};
        run_instr("jmp", 3'b110, 3);
        trace = '{E_IF, E_ZERO, E_JZ, E_ZERO, E_ZERO, E_ZERO, E_ZERO, E_ZERO};
        run_instr("jz", 3'b111, 3);

        // SUB up to EXEC, then reset mid-cycle
        trace = '{E_IF, E_ZERO, E_POP1, E_POP2, E_ZERO, E_ZERO, E_ZERO, E_ZERO};
        run_instr("sub2", 3'b001, 4);
        check("sub2_exec", outs, E_EXSUB);
        #2 rst = 1'b0;
        #1 check("async_reset_drop", outs, E_ZERO);
        @(negedge clk);
        check("reset_held_no_push", outs, E_ZERO);
        rst = 1'b1;
        #1 check("init_after_midreset", outs, E_ZERO);
        @(negedge clk);
        check("if_after_midreset", outs, E_IF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
